// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter
//  Description : Parametrised up/down counter with modulus, wrap or saturate
//                boundary handling, enable prescaler, synchronous clear/load
//                and a registered terminal-count pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     counter width in bits (2..32)
//    MAX_VAL   highest count value (1..2**WIDTH-1); count range 0..MAX_VAL
//    SATURATE  0 = wrap at the boundaries, 1 = hold at the boundaries
//    PRESCALE  enabled cycles per count step (1..256)
//  Ports
//    clk       rising-edge clock
//    reset     asynchronous active-low reset
//    clr       synchronous clear (highest priority)
//    load      synchronous load of cnt_in, clamped to MAX_VAL
//    enb       count enable, feeds the prescaler
//    up_dn     direction: 1 = up, 0 = down
//    cnt_in    load value
//    cnt_out   registered count
//    at_max    combinational, cnt_out == MAX_VAL
//    at_min    combinational, cnt_out == 0
//    tc_pulse  one-cycle pulse following a boundary step
// ============================================================================
module param_updown_counter #(
    parameter int     WIDTH    = 8,
    parameter longint MAX_VAL  = 255,
    parameter int     SATURATE = 0,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             enb,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             at_max,
    output logic             at_min,
    output logic             tc_pulse
);

    // All boundary arithmetic runs one bit wider than the counter so that a
    // modulus of 2**WIDTH-1 produces a visible carry instead of aliasing.
    localparam logic [WIDTH:0]   c_MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   c_ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] c_MAX     = c_MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;

    logic             w_pre_last;
    logic             w_step;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_cnt_inc;
    logic [WIDTH:0]   w_cnt_dec;
    logic [WIDTH:0]   w_in_ext;

    logic             w_up_bound;
    logic             w_dn_bound;

    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_up_val;
    logic [WIDTH-1:0] w_dn_val;
    logic [WIDTH-1:0] w_load_val;

    // ------------------------------------------------------------------------
    // Prescaler: w_pre_last marks the enabled cycle on which a step fires.
    // Clear and load discard partial progress; enb low simply freezes it.
    // ------------------------------------------------------------------------
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int                 c_PRE_W    = $clog2(PRESCALE);
            localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);

            logic [c_PRE_W-1:0] r_pre_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pre_cnt <= '0;
                end else if (clr || load) begin
                    r_pre_cnt <= '0;
                end else if (enb) begin
                    if (r_pre_cnt == c_PRE_LAST) begin
                        r_pre_cnt <= '0;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
                    end
                end
            end

            assign w_pre_last = (r_pre_cnt == c_PRE_LAST);
        end else begin : g_no_prescale
            // Every enabled edge is a step.
            assign w_pre_last = 1'b1;
        end
    endgenerate

    assign w_step = enb & w_pre_last;

    // ------------------------------------------------------------------------
    // Boundary values: what the count becomes when a step crosses an end.
    // ------------------------------------------------------------------------
    generate
        if (SATURATE != 0) begin : g_saturate
            assign w_up_wrap = c_MAX;
            assign w_dn_wrap = '0;
        end else begin : g_wrap
            assign w_up_wrap = '0;
            assign w_dn_wrap = c_MAX;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-count arithmetic. The up boundary is detected as the widened
    // increment exceeding MAX_VAL; the down boundary is the borrow out of
    // the widened decrement (only possible from zero).
    // ------------------------------------------------------------------------
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_cnt_inc  = w_cnt_ext + c_ONE_EXT;
    assign w_cnt_dec  = w_cnt_ext - c_ONE_EXT;

    assign w_up_bound = (w_cnt_inc > c_MAX_EXT);
    assign w_dn_bound = w_cnt_dec[WIDTH];

    assign w_up_val   = w_up_bound ? w_up_wrap : w_cnt_inc[WIDTH-1:0];
    assign w_dn_val   = w_dn_bound ? w_dn_wrap : w_cnt_dec[WIDTH-1:0];

    // Loads above the modulus are clamped so the count never leaves range.
    assign w_in_ext   = {1'b0, cnt_in};
    assign w_load_val = (w_in_ext > c_MAX_EXT) ? c_MAX : cnt_in;

    // ------------------------------------------------------------------------
    // Count and terminal-count registers. Priority: clr > load > step.
    // tc is rewritten on every edge so it can never stretch past one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else if (load) begin
            r_cnt <= w_load_val;
            r_tc  <= 1'b0;
        end else if (w_step) begin
            if (up_dn) begin
                r_cnt <= w_up_val;
                r_tc  <= w_up_bound;
            end else begin
                r_cnt <= w_dn_val;
                r_tc  <= w_dn_bound;
            end
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign cnt_out  = r_cnt;
    assign tc_pulse = r_tc;
    assign at_max   = (r_cnt == c_MAX);
    assign at_min   = (r_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_updown_counter
//  Description : Self-checking bench for param_updown_counter. Four instances
//                with different parameter sets share one stimulus stream and
//                are compared every cycle against a behavioural model, plus
//                directed sequences with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_updown_counter;

    // Instance parameter sets: A wrap, B saturate, C full-range prescaled,
    // D saturate prescaled at width 5.
    localparam int c_W  [4] = '{4, 4, 8, 5};
    localparam int c_MAX[4] = '{9, 9, 255, 31};
    localparam int c_SAT[4] = '{0, 1, 0, 1};
    localparam int c_PRE[4] = '{1, 1, 3, 4};

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic       enb;
    logic       up_dn;
    logic [7:0] cnt_in;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic [4:0] cnt_d;
    logic       amax_a, amin_a, tc_a;
    logic       amax_b, amin_b, tc_b;
    logic       amax_c, amin_c, tc_c;
    logic       amax_d, amin_d, tc_d;

    int total = 0;
    int bad   = 0;

    int m_cnt[4];
    int m_pre[4];
    int m_tc [4];

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .enb(enb), .up_dn(up_dn),
        .cnt_in(cnt_in[3:0]), .cnt_out(cnt_a), .at_max(amax_a), .at_min(amin_a), .tc_pulse(tc_a));

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .enb(enb), .up_dn(up_dn),
        .cnt_in(cnt_in[3:0]), .cnt_out(cnt_b), .at_max(amax_b), .at_min(amin_b), .tc_pulse(tc_b));

    param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .PRESCALE(3)) u_c (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .enb(enb), .up_dn(up_dn),
        .cnt_in(cnt_in), .cnt_out(cnt_c), .at_max(amax_c), .at_min(amin_c), .tc_pulse(tc_c));

    param_updown_counter #(.WIDTH(5), .MAX_VAL(31), .SATURATE(1), .PRESCALE(4)) u_d (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .enb(enb), .up_dn(up_dn),
        .cnt_in(cnt_in[4:0]), .cnt_out(cnt_d), .at_max(amax_d), .at_min(amin_d), .tc_pulse(tc_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: counts in plain integers, one instance per index.
    // ------------------------------------------------------------------------
    function automatic void model_edge(input int i);
        int v;
        v = int'(cnt_in) & ((1 << c_W[i]) - 1);
        if (clr) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
        end else if (load) begin
            m_cnt[i] = (v > c_MAX[i]) ? c_MAX[i] : v;
            m_pre[i] = 0; m_tc[i] = 0;
        end else if (enb) begin
            m_tc[i]  = 0;
            m_pre[i] = m_pre[i] + 1;
            if (m_pre[i] == c_PRE[i]) begin
                m_pre[i] = 0;
                if (up_dn) begin
                    if (m_cnt[i] == c_MAX[i]) begin
                        m_cnt[i] = (c_SAT[i] != 0) ? c_MAX[i] : 0;
                        m_tc[i]  = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    if (m_cnt[i] == 0) begin
                        m_cnt[i] = (c_SAT[i] != 0) ? 0 : c_MAX[i];
                        m_tc[i]  = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end
        end else begin
            m_tc[i] = 0;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) model_edge(i);
        end
    end

    task automatic cmp_one(input string nm, input int i, input int cnt,
                           input int amax, input int amin, input int tc);
        check({nm, "_cnt"},    cnt,  m_cnt[i]);
        check({nm, "_at_max"}, amax, int'(m_cnt[i] == c_MAX[i]));
        check({nm, "_at_min"}, amin, int'(m_cnt[i] == 0));
        check({nm, "_tc"},     tc,   m_tc[i]);
    endtask

    // Single compare process, sampling 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        cmp_one("A", 0, int'(cnt_a), int'(amax_a), int'(amin_a), int'(tc_a));
        cmp_one("B", 1, int'(cnt_b), int'(amax_b), int'(amin_b), int'(tc_b));
        cmp_one("C", 2, int'(cnt_c), int'(amax_c), int'(amin_c), int'(tc_c));
        cmp_one("D", 3, int'(cnt_d), int'(amax_d), int'(amin_d), int'(tc_d));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus: directed sequences with literal expectations, then random.
    // ------------------------------------------------------------------------
    initial begin
        int e_cnt[4];
        int e_tc [4];
        int e_pc [9];

        reset = 1'b1; clr = 1'b0; load = 1'b0; enb = 1'b0; up_dn = 1'b1; cnt_in = '0;
        #2 reset = 1'b0;
        repeat (2) tick();
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_min_a", int'(amin_a), 1);
        check("rst_max_a", int'(amax_a), 0);
        check("rst_tc_a",  int'(tc_a),   0);

        reset = 1'b1;
        repeat (5) tick();
        check("hold_cnt_a", int'(cnt_a), 0);

        // Load beats enable and clamps above the modulus.
        load = 1'b1; enb = 1'b1; cnt_in = 8'h0D;
        tick();
        check("clamp_cnt_a", int'(cnt_a), 9);
        check("clamp_max_a", int'(amax_a), 1);
        check("clamp_cnt_c", int'(cnt_c), 13);
        clr = 1'b1;
        tick();
        check("clr_over_load_a", int'(cnt_a), 0);
        clr = 1'b0;

        // Wrap up from 7 then down through zero on A.
        cnt_in = 8'd7;
        tick();
        load = 1'b0; up_dn = 1'b1;
        e_cnt = '{8, 9, 0, 1};
        e_tc  = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_up_cnt_a", int'(cnt_a), e_cnt[k]);
            check("wrap_up_tc_a",  int'(tc_a),  e_tc[k]);
        end
        up_dn = 1'b0;
        tick();
        check("wrap_dn_cnt_a", int'(cnt_a), 0);
        check("wrap_dn_tc_a",  int'(tc_a),  0);
        tick();
        check("wrap_dn_cnt_a", int'(cnt_a), 9);
        check("wrap_dn_tc_a",  int'(tc_a),  1);

        // Saturation on B.
        cnt_in = 8'd8; load = 1'b1;
        tick();
        load = 1'b0; up_dn = 1'b1;
        e_cnt = '{9, 9, 9, 9};
        e_tc  = '{0, 1, 1, 1};
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_up_cnt_b", int'(cnt_b), e_cnt[k]);
            check("sat_up_tc_b",  int'(tc_b),  e_tc[k]);
        end
        cnt_in = 8'd1; load = 1'b1;
        tick();
        load = 1'b0; up_dn = 1'b0;
        tick();
        check("sat_dn_cnt_b", int'(cnt_b), 0);
        check("sat_dn_tc_b",  int'(tc_b),  0);
        tick();
        check("sat_dn_cnt_b", int'(cnt_b), 0);
        check("sat_dn_tc_b",  int'(tc_b),  1);

        // Prescale by 3 on C.
        clr = 1'b1; up_dn = 1'b1;
        tick();
        clr = 1'b0;
        e_pc = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
        for (int k = 0; k < 9; k++) begin
            tick();
            check("pre_cnt_c", int'(cnt_c), e_pc[k]);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        check("pre_gap7_c", int'(cnt_c), 2);
        enb = 1'b0;
        repeat (2) tick();
        check("pre_frozen_c", int'(cnt_c), 2);
        enb = 1'b1;
        tick();
        check("pre_cyc10_c", int'(cnt_c), 2);
        tick();
        check("pre_cyc11_c", int'(cnt_c), 3);

        // Full-range wrap on C.
        cnt_in = 8'd254; load = 1'b1;
        tick();
        load = 1'b0;
        check("full_load_c", int'(cnt_c), 254);
        repeat (3) tick();
        check("full_255_c",  int'(cnt_c),  255);
        check("full_max_c",  int'(amax_c), 1);
        check("full_tc0_c",  int'(tc_c),   0);
        repeat (3) tick();
        check("full_wrap_c", int'(cnt_c),  0);
        check("full_tc1_c",  int'(tc_c),   1);
        check("full_nmax_c", int'(amax_c), 0);
        tick();
        check("full_tcoff_c", int'(tc_c), 0);

        // Asynchronous reset between clock edges.
        cnt_in = 8'd5; load = 1'b1;
        tick();
        load = 1'b0;
        check("pre_areset_a", int'(cnt_a), 5);
        #2 reset = 1'b0;
        #1;
        check("areset_cnt_a", int'(cnt_a),  0);
        check("areset_min_a", int'(amin_a), 1);
        check("areset_max_a", int'(amax_a), 0);
        check("areset_tc_a",  int'(tc_a),   0);
        tick();
        reset = 1'b1;

        // Randomised phase; direction is sticky so boundaries get reached.
        for (int n = 0; n < 4000; n++) begin
            cnt_in = 8'($urandom);
            enb    = ($urandom_range(0, 3) != 0);
            clr    = ($urandom_range(0, 63) == 0);
            load   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
